// File: rtl/disp_param_sched.sv
// Display parameter scheduler: chooses which camera parameter the seven-segment controller shows.
// Optional output clamp to decodable codes is enabled with `define DISP_PARAM_CLAMP_EN.
module disp_param_sched #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] iso_value,
  input  logic [3:0] shutter_value,
  input  logic [3:0] focal_value,
  input  logic [2:0] indicator_value,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic [3:0] display_value,
  output logic [1:0] display_select,
  output logic       override_active
);

  typedef enum logic [0:0] {StBase, StOvr} state_e;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       base_sel_q, base_sel_d;
  logic [1:0]       ovr_sel_q, ovr_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       iso_q, shutter_q, focal_q;
  logic [2:0]       indicator_q;
  logic             prime_q;
  logic             auto_en_q;

  logic [3:0]       chg;
  logic             any_chg;
  logic [1:0]       chg_idx;
  logic [1:0]       show_sel;
  logic [3:0]       raw_val;
  logic [3:0]       show_val;

  // Shadows hold last cycle's inputs; nothing is compared until they have been primed.
  always_comb begin
    chg = 4'b0000;
    if (prime_q) begin
      chg[0] = iso_value != iso_q;
      chg[1] = shutter_value != shutter_q;
      chg[2] = focal_value != focal_q;
      chg[3] = indicator_value != indicator_q;
    end
    any_chg = |chg;
    if (chg[0]) begin
      chg_idx = 2'd0;
    end else if (chg[1]) begin
      chg_idx = 2'd1;
    end else if (chg[2]) begin
      chg_idx = 2'd2;
    end else begin
      chg_idx = 2'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_sel_d = base_sel_q;
    ovr_sel_d  = ovr_sel_q;
    cnt_d      = cnt_q;
    if (prime_q) begin
      case (state_q)
        StBase: begin
          // The button still advances the base selection when a change override wins.
          if (btn_next) begin
            base_sel_d = base_sel_q + 2'd1;
          end
          if (any_chg) begin
            state_d   = StOvr;
            ovr_sel_d = chg_idx;
            cnt_d     = '0;
          end else if (btn_next || !auto_en || (auto_en != auto_en_q)) begin
            cnt_d = '0;
          end else if (cnt_q == DwellLast) begin
            base_sel_d = base_sel_q + 2'd1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOvr: begin
          if (any_chg) begin
            ovr_sel_d = chg_idx;
            cnt_d     = '0;
          end else if (btn_next) begin
            state_d    = StBase;
            base_sel_d = base_sel_q + 2'd1;
            cnt_d      = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = StBase;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StBase;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next selection so they trail a change by one clock.
  always_comb begin
    show_sel = (state_d == StOvr) ? ovr_sel_d : base_sel_d;
    case (show_sel)
      2'd0:    raw_val = iso_value;
      2'd1:    raw_val = shutter_value;
      2'd2:    raw_val = focal_value;
      default: raw_val = {1'b0, indicator_value};
    endcase
    show_val = raw_val;
`ifdef DISP_PARAM_CLAMP_EN
    case (show_sel)
      2'd0:    if (raw_val == 4'd15) show_val = 4'd14;
      2'd2:    if (raw_val >= 4'd12) show_val = 4'd11;
      2'd3:    if (raw_val >= 4'd6)  show_val = 4'd5;
      default: show_val = raw_val;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StBase;
      base_sel_q      <= 2'd0;
      ovr_sel_q       <= 2'd0;
      cnt_q           <= '0;
      iso_q           <= 4'd0;
      shutter_q       <= 4'd0;
      focal_q         <= 4'd0;
      indicator_q     <= 3'd0;
      prime_q         <= 1'b0;
      auto_en_q       <= 1'b0;
      display_value   <= 4'd0;
      display_select  <= 2'd0;
      override_active <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_sel_q      <= base_sel_d;
      ovr_sel_q       <= ovr_sel_d;
      cnt_q           <= cnt_d;
      iso_q           <= iso_value;
      shutter_q       <= shutter_value;
      focal_q         <= focal_value;
      indicator_q     <= indicator_value;
      prime_q         <= 1'b1;
      auto_en_q       <= auto_en;
      display_value   <= show_val;
      display_select  <= show_sel;
      override_active <= (state_d == StOvr);
    end
  end

endmodule

// File: tb/tb_disp_param_sched.sv
// Directed self-checking bench for disp_param_sched (DWELL_CYCLES=4, HOLD_CYCLES=3).
module tb_disp_param_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] iso_value, shutter_value, focal_value;
  logic [2:0] indicator_value;
  logic       btn_next, auto_en;
  logic [3:0] display_value;
  logic [1:0] display_select;
  logic       override_active;

  int tests = 0;
  int fails = 0;

`ifdef DISP_PARAM_CLAMP_EN
  localparam logic [3:0] Iso15Exp = 4'd14;
  localparam logic [3:0] Ind7Exp  = 4'd5;
  localparam logic [3:0] Foc13Exp = 4'd11;
`else
  localparam logic [3:0] Iso15Exp = 4'd15;
  localparam logic [3:0] Ind7Exp  = 4'd7;
  localparam logic [3:0] Foc13Exp = 4'd13;
`endif

  always #5 clk = ~clk;

  disp_param_sched #(
    .DWELL_CYCLES(4),
    .HOLD_CYCLES (3),
    .CNT_W       (3)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .iso_value      (iso_value),
    .shutter_value  (shutter_value),
    .focal_value    (focal_value),
    .indicator_value(indicator_value),
    .btn_next       (btn_next),
    .auto_en        (auto_en),
    .display_value  (display_value),
    .display_select (display_select),
    .override_active(override_active)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [1:0] es, input logic [3:0] ev,
                       input logic eo);
    tests += 3;
    assert (display_select === es) else begin
      fails++;
      $error("FAIL %s select got %0d expected %0d", tag, display_select, es);
    end
    assert (display_value === ev) else begin
      fails++;
      $error("FAIL %s value got %0d expected %0d", tag, display_value, ev);
    end
    assert (override_active === eo) else begin
      fails++;
      $error("FAIL %s override got %0b expected %0b", tag, override_active, eo);
    end
  endtask

  task automatic pulse_btn();
    btn_next = 1'b1;
    tick(1);
    btn_next = 1'b0;
  endtask

  initial begin
    logic [3:0] auto_vals [4];
    auto_vals = '{4'd5, 4'd2, 4'd7, 4'd2};

    rstn = 1'b0;
    iso_value = 4'd5;
    shutter_value = 4'd2;
    focal_value = 4'd7;
    indicator_value = 3'd2;
    btn_next = 1'b0;
    auto_en = 1'b0;
    tick(2);
    check("reset", 2'd0, 4'd0, 1'b0);

    // Release; prime cycle must not look like a change from the zeroed shadows.
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("prime_idle", 2'd0, 4'd5, 1'b0);
    end

    // Auto-cycle: selection advances every 4 clocks.
    auto_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      logic [1:0] s;
      tick(1);
      s = 2'(((i - 1) / 4) % 4);
      check("auto_cycle", s, auto_vals[s], 1'b0);
    end

    // Auto off: selection frozen.
    auto_en = 1'b0;
    tick(6);
    check("auto_off_hold", 2'd0, 4'd5, 1'b0);

    pulse_btn();
    check("btn_to1", 2'd1, 4'd2, 1'b0);
    pulse_btn();
    check("btn_to2", 2'd2, 4'd7, 1'b0);
    pulse_btn();
    check("btn_to3", 2'd3, 4'd2, 1'b0);
    pulse_btn();
    check("btn_wrap0", 2'd0, 4'd5, 1'b0);
    tick(2);
    check("btn_idle", 2'd0, 4'd5, 1'b0);

    // Focal change forces an override for 3 clocks.
    focal_value = 4'd9;
    tick(1);
    check("ovr_focal_c0", 2'd2, 4'd9, 1'b1);
    tick(1);
    check("ovr_focal_c1", 2'd2, 4'd9, 1'b1);
    tick(1);
    check("ovr_focal_c2", 2'd2, 4'd9, 1'b1);
    tick(1);
    check("ovr_expire", 2'd0, 4'd5, 1'b0);

    // New override; an ISO change partway through restarts the hold.
    focal_value = 4'd3;
    tick(1);
    check("ovr2_c0", 2'd2, 4'd3, 1'b1);
    tick(1);
    check("ovr2_c1", 2'd2, 4'd3, 1'b1);
    iso_value = 4'd8;
    tick(1);
    check("ovr_iso_restart", 2'd0, 4'd8, 1'b1);
    tick(1);
    check("ovr_iso_held", 2'd0, 4'd8, 1'b1);
    pulse_btn();
    check("ovr_btn_exit", 2'd1, 4'd2, 1'b0);

    // Simultaneous shutter and indicator change: shutter wins.
    shutter_value = 4'd4;
    indicator_value = 3'd7;
    tick(1);
    check("ovr_prio", 2'd1, 4'd4, 1'b1);
    tick(3);
    check("ovr_prio_expire", 2'd1, 4'd4, 1'b0);

    // Clamp behaviour (or raw pass-through).
    iso_value = 4'd15;
    tick(1);
    check("iso15", 2'd0, Iso15Exp, 1'b1);
    tick(3);
    check("iso15_expire", 2'd1, 4'd4, 1'b0);
    pulse_btn();
    check("focal3", 2'd2, 4'd3, 1'b0);
    pulse_btn();
    check("ind7", 2'd3, Ind7Exp, 1'b0);
    focal_value = 4'd13;
    tick(1);
    check("focal13", 2'd2, Foc13Exp, 1'b1);

    // Asynchronous reset mid-override, then prime repeats.
    #2 rstn = 1'b0;
    #1 check("async_reset", 2'd0, 4'd0, 1'b0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    check("reprime", 2'd0, Iso15Exp, 1'b0);
    tick(1);
    check("reprime_idle", 2'd0, Iso15Exp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
